// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and constants for the memory-game level logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam int          MAX_SEQ   = 32;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : seq_lfsr
//  Description : 32-bit right-shift Galois LFSR, advances only when stepped.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_lfsr
    import game_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0155_5555
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [31:0] out
);

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    localparam logic [31:0] c_SEED = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= c_SEED;
        end else if (step) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign out = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/seq_level_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : seq_level_fsm
//  Description : One game level: draws a sequence, checks entries MSB-first.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_level_fsm
    import game_pkg::*;
#(
    parameter int          SEQ_LEN = 25,
    parameter int          LIVES   = 3,
    parameter int          COMBO_W = 5,
    parameter logic [31:0] SEED    = 32'h0155_5555
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           entry_valid,
    input  logic                           entry_bit,
    output logic [SEQ_LEN-1:0]             seq,
    output logic [$clog2(SEQ_LEN+1)-1:0]   pos,
    output logic [3:0]                     lives_left,
    output logic [COMBO_W-1:0]             combo,
    output logic                           hit,
    output logic                           miss,
    output logic                           win,
    output logic                           lose,
    output logic [1:0]                     o_state
);

    localparam int                 POS_W       = $clog2(SEQ_LEN + 1);
    localparam logic [POS_W-1:0]   c_LAST_POS  = POS_W'(SEQ_LEN - 1);
    localparam logic [3:0]         c_LIVES     = 4'(LIVES);
    localparam logic [COMBO_W-1:0] c_COMBO_MAX = {COMBO_W{1'b1}};
    localparam logic [SEQ_LEN-1:0] c_MSB       = SEQ_LEN'(1) << (SEQ_LEN - 1);

    state_t               r_state;
    logic [SEQ_LEN-1:0]   r_seq;
    logic [POS_W-1:0]     r_pos;
    logic [3:0]           r_lives;
    logic [COMBO_W-1:0]   r_combo;
    logic                 r_hit;
    logic                 r_miss;
    logic                 r_win;
    logic                 r_lose;

    logic [31:0]          w_lfsr;
    logic [SEQ_LEN-1:0]   w_seq_next;
    logic [SEQ_LEN-1:0]   w_bit_mask;
    logic                 w_exp_bit;
    logic                 w_match;

    seq_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (start),
        .out   (w_lfsr)
    );

    assign w_seq_next = SEQ_LEN'(w_lfsr);

    // Walking mask selects seq[SEQ_LEN-1-pos]; pos < SEQ_LEN whenever PLAY.
    assign w_bit_mask = c_MSB >> r_pos;
    assign w_exp_bit  = |(r_seq & w_bit_mask);
    assign w_match    = (entry_bit == w_exp_bit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_seq   <= '0;
            r_pos   <= '0;
            r_lives <= c_LIVES;
            r_combo <= '0;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
            if (start) begin
                r_seq   <= w_seq_next;
                r_pos   <= '0;
                r_lives <= c_LIVES;
                r_combo <= '0;
                r_win   <= 1'b0;
                r_lose  <= 1'b0;
                r_state <= ST_PLAY;
            end else if (entry_valid && (r_state == ST_PLAY)) begin
                if (w_match) begin
                    r_hit <= 1'b1;
                    r_pos <= r_pos + POS_W'(1);
                    if (r_combo != c_COMBO_MAX) begin
                        r_combo <= r_combo + COMBO_W'(1);
                    end
                    if (r_pos == c_LAST_POS) begin
                        r_state <= ST_WIN;
                        r_win   <= 1'b1;
                    end
                end else begin
                    r_miss  <= 1'b1;
                    r_combo <= '0;
                    r_lives <= r_lives - 4'd1;
                    if (r_lives == 4'd1) begin
                        r_state <= ST_LOSE;
                        r_lose  <= 1'b1;
                    end
                end
            end
        end
    end

    assign seq        = r_seq;
    assign pos        = r_pos;
    assign lives_left = r_lives;
    assign combo      = r_combo;
    assign hit        = r_hit;
    assign miss       = r_miss;
    assign win        = r_win;
    assign lose       = r_lose;
    assign o_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_level_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_level_fsm
//  Description : Self-checking bench for seq_level_fsm, two configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_level_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, entry_valid, entry_bit;

    logic [3:0] a_seq;  logic [2:0] a_pos;  logic [3:0] a_lives; logic [4:0] a_combo;
    logic a_hit, a_miss, a_win, a_lose;     logic [1:0] a_state;
    logic [7:0] b_seq;  logic [3:0] b_pos;  logic [3:0] b_lives; logic [1:0] b_combo;
    logic b_hit, b_miss, b_win, b_lose;     logic [1:0] b_state;

    seq_level_fsm #(.SEQ_LEN(4), .LIVES(2), .COMBO_W(5), .SEED(32'hA)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .entry_valid(entry_valid),
        .entry_bit(entry_bit), .seq(a_seq), .pos(a_pos), .lives_left(a_lives),
        .combo(a_combo), .hit(a_hit), .miss(a_miss), .win(a_win), .lose(a_lose),
        .o_state(a_state)
    );

    seq_level_fsm #(.SEQ_LEN(8), .LIVES(3), .COMBO_W(2), .SEED(32'hFF)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .entry_valid(entry_valid),
        .entry_bit(entry_bit), .seq(b_seq), .pos(b_pos), .lives_left(b_lives),
        .combo(b_combo), .hit(b_hit), .miss(b_miss), .win(b_win), .lose(b_lose),
        .o_state(b_state)
    );

    // Common packed view: {seq32, pos8, lives4, combo8, hit, miss, win, lose, state2}
    logic [57:0] a_act, b_act;
    assign a_act = {28'b0, a_seq, 5'b0, a_pos, a_lives, 3'b0, a_combo,
                    a_hit, a_miss, a_win, a_lose, a_state};
    assign b_act = {24'b0, b_seq, 4'b0, b_pos, b_lives, 6'b0, b_combo,
                    b_hit, b_miss, b_win, b_lose, b_state};

    typedef struct {
        logic [31:0] lfsr;
        logic [31:0] seq;
        int          pos;
        int          lives;
        int          combo;
        bit          hit, miss, win, lose, active;
    } mdl_t;

    typedef struct {
        string       name;
        bit          r, s, v, b;
        logic [57:0] exp;
    } vec_t;

    mdl_t ma, mb;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [57:0] mk(logic [31:0] sq, int p, int lv, int cb,
                                       bit h, bit mi, bit w, bit lo, int st);
        return {sq, 8'(p), 4'(lv), 8'(cb), h, mi, w, lo, 2'(st)};
    endfunction

    // Game rules applied directly: one call per clock with that cycle's inputs.
    function automatic mdl_t mstep(mdl_t m, bit r, bit s, bit v, bit b,
                                   int L, int LV, int CM, logic [31:0] seed);
        mdl_t n = m;
        bit   expb;
        n.hit  = 0;
        n.miss = 0;
        if (r) begin
            n.lfsr = (seed == 0) ? 32'h1 : seed;
            n.seq = 0; n.pos = 0; n.lives = LV; n.combo = 0;
            n.win = 0; n.lose = 0; n.active = 0;
        end else if (s) begin
            n.seq  = (L == 32) ? m.lfsr : (m.lfsr % (32'h1 << L));
            n.lfsr = (m.lfsr >> 1) ^ (m.lfsr[0] ? 32'h8020_0003 : 32'h0);
            n.pos = 0; n.lives = LV; n.combo = 0;
            n.win = 0; n.lose = 0; n.active = 1;
        end else if (v && m.active) begin
            expb = ((m.seq >> (L - 1 - m.pos)) & 1) != 0;
            if (b == expb) begin
                n.hit   = 1;
                n.pos   = m.pos + 1;
                n.combo = (m.combo + 1 > CM) ? CM : m.combo + 1;
                if (n.pos == L) begin
                    n.active = 0;
                    n.win    = 1;
                end
            end else begin
                n.miss  = 1;
                n.combo = 0;
                n.lives = m.lives - 1;
                if (n.lives == 0) begin
                    n.active = 0;
                    n.lose   = 1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [57:0] mpack(mdl_t m);
        int st;
        st = m.active ? 1 : m.win ? 2 : m.lose ? 3 : 0;
        return mk(m.seq, m.pos, m.lives, m.combo, m.hit, m.miss, m.win, m.lose, st);
    endfunction

    task automatic chk(string nm, logic [57:0] act, logic [57:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(bit r, bit s, bit v, bit b);
        reset = r; start = s; entry_valid = v; entry_bit = b;
        @(posedge clk);
        ma = mstep(ma, r, s, v, b, 4, 2, 31, 32'hA);
        mb = mstep(mb, r, s, v, b, 8, 3, 3, 32'hFF);
        #1;
        chk("model_a", a_act, mpack(ma));
        chk("model_b", b_act, mpack(mb));
    endtask

    vec_t tbl[$];
    bit   rr, ss, vv, bb, good;

    initial begin
        reset = 1'b1; start = 1'b0; entry_valid = 1'b0; entry_bit = 1'b0;

        // Config A: SEQ_LEN=4 LIVES=2 SEED=A -> first seq 1010, second 0101.
        tbl.push_back('{"rst",          1,0,0,0, mk(0,   0,2,0, 0,0,0,0, 0)});
        tbl.push_back('{"start",        0,1,0,0, mk(4'hA,0,2,0, 0,0,0,0, 1)});
        tbl.push_back('{"hit1",         0,0,1,1, mk(4'hA,1,2,1, 1,0,0,0, 1)});
        tbl.push_back('{"hit2",         0,0,1,0, mk(4'hA,2,2,2, 1,0,0,0, 1)});
        tbl.push_back('{"hit3",         0,0,1,1, mk(4'hA,3,2,3, 1,0,0,0, 1)});
        tbl.push_back('{"hit4_win",     0,0,1,0, mk(4'hA,4,2,4, 1,0,1,0, 2)});
        tbl.push_back('{"win_ignore",   0,0,1,1, mk(4'hA,4,2,4, 0,0,1,0, 2)});
        tbl.push_back('{"win_hold",     0,0,0,0, mk(4'hA,4,2,4, 0,0,1,0, 2)});
        tbl.push_back('{"restart",      0,1,0,0, mk(4'h5,0,2,0, 0,0,0,0, 1)});
        tbl.push_back('{"rst2",         1,0,0,0, mk(0,   0,2,0, 0,0,0,0, 0)});
        tbl.push_back('{"start2",       0,1,0,0, mk(4'hA,0,2,0, 0,0,0,0, 1)});
        tbl.push_back('{"miss1",        0,0,1,0, mk(4'hA,0,1,0, 0,1,0,0, 1)});
        tbl.push_back('{"miss_clear",   0,0,0,0, mk(4'hA,0,1,0, 0,0,0,0, 1)});
        tbl.push_back('{"miss2_lose",   0,0,1,0, mk(4'hA,0,0,0, 0,1,0,1, 3)});
        tbl.push_back('{"lose_ign1",    0,0,1,1, mk(4'hA,0,0,0, 0,0,0,1, 3)});
        tbl.push_back('{"lose_ign0",    0,0,1,0, mk(4'hA,0,0,0, 0,0,0,1, 3)});
        tbl.push_back('{"rst3",         1,0,0,0, mk(0,   0,2,0, 0,0,0,0, 0)});
        tbl.push_back('{"start3",       0,1,0,0, mk(4'hA,0,2,0, 0,0,0,0, 1)});
        tbl.push_back('{"hit_b2b",      0,0,1,1, mk(4'hA,1,2,1, 1,0,0,0, 1)});
        tbl.push_back('{"start_prio",   0,1,1,0, mk(4'h5,0,2,0, 0,0,0,0, 1)});

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].b);
            chk(tbl[i].name, a_act, tbl[i].exp);
        end

        // Mid-game reset at pos=2, lives=1: LFSR must replay SEED.
        apply(1, 0, 0, 0);
        apply(0, 1, 0, 0);
        apply(0, 0, 1, 1);
        apply(0, 0, 1, 1);
        chk("pre_rst_miss", a_act, mk(4'hA, 1, 1, 0, 0, 1, 0, 0, 1));
        apply(0, 0, 1, 0);
        chk("pre_rst_pos2", a_act, mk(4'hA, 2, 1, 1, 1, 0, 0, 0, 1));
        apply(1, 0, 0, 0);
        chk("midgame_rst", a_act, mk(0, 0, 2, 0, 0, 0, 0, 0, 0));
        apply(0, 1, 0, 0);
        chk("seed_replay", a_act, mk(4'hA, 0, 2, 0, 0, 0, 0, 0, 1));

        // Config B: SEQ_LEN=8 COMBO_W=2 SEED=FF, eight 1s saturate combo at 3.
        apply(1, 0, 0, 0);
        chk("b_rst", b_act, mk(0, 0, 3, 0, 0, 0, 0, 0, 0));
        apply(0, 1, 0, 0);
        chk("b_start", b_act, mk(8'hFF, 0, 3, 0, 0, 0, 0, 0, 1));
        for (int k = 1; k <= 8; k++) begin
            apply(0, 0, 1, 1);
            chk($sformatf("b_sat%0d", k), b_act,
                mk(8'hFF, k, 3, (k > 3) ? 3 : k, 1, 0, k == 8, 0, (k == 8) ? 2 : 1));
        end

        // Random play, biased toward correct guesses for game A.
        for (int n = 0; n < 3000; n++) begin
            rr = ($urandom_range(0, 99) < 2);
            ss = ($urandom_range(0, 99) < 6);
            vv = ($urandom_range(0, 99) < 60);
            good = ma.active ? (((ma.seq >> (3 - ma.pos)) & 1) != 0) : 1'b0;
            bb = ($urandom_range(0, 99) < 75) ? good : 1'($urandom_range(0, 1));
            apply(rr, ss, vv, bb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
